// File: rtl/aes_pkg.sv
// Shared AES byte-serial types and the ShiftRows index rule.
// Byte k of a state is row k%4, column k/4; element 0 is the most significant byte.
package aes_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int ROWS        = 4;

    typedef logic [7:0] aes_byte_t;
    typedef aes_byte_t [0:BLOCK_BYTES-1] aes_state_t;

    // Output byte k is taken from source index returned here.
    // Forward rotates row r left by r; inverse rotates it right by r.
    function automatic logic [3:0] sr_src_idx(input logic [3:0] k, input logic inverse);
        int row;
        int col;
        int src_col;
        row     = int'(k) % ROWS;
        col     = int'(k) / ROWS;
        src_col = inverse ? (col - row + ROWS) % ROWS : (col + row) % ROWS;
        return 4'(src_col * ROWS + row);
    endfunction

endpackage

// File: rtl/shift_rows_index.sv
// Combinational read-count to source-byte index for byte-serial ShiftRows.
// Shared between the encrypt stream and the future byte-serial decrypt path.
module shift_rows_index
    import aes_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic [3:0] idx_i,
    output logic [3:0] src_o
);

    always_comb begin
        src_o = sr_src_idx(idx_i, INVERSE);
    end

endmodule

// File: rtl/shift_rows_stream.sv
// Byte-serial AES ShiftRows with ping-pong banks: one bank fills while the other drains,
// so back-to-back blocks stream at one byte per cycle in both directions.
module shift_rows_stream
    import aes_pkg::*;
#(
    parameter bit INVERSE    = 1'b0,
    parameter bit CHECK_LAST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       err_align,
    output logic       busy
);

    localparam logic [3:0] LAST_IDX = 4'(BLOCK_BYTES - 1);

    aes_state_t bank_q [2];
    aes_state_t bank_d [2];
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [3:0] wr_cnt_q, wr_cnt_d;
    logic [3:0] rd_cnt_q, rd_cnt_d;
    logic [1:0] full_q, full_d;
    logic       err_align_q, err_align_d;
    logic       s_fire, m_fire;
    logic [3:0] src_idx;

    shift_rows_index #(.INVERSE(INVERSE)) u_index (
        .idx_i (rd_cnt_q),
        .src_o (src_idx)
    );

    // Every output is a function of registers only; nothing on s_* reaches m_*.
    always_comb begin
        s_ready   = !full_q[wr_bank_q];
        m_valid   = full_q[rd_bank_q];
        m_data    = bank_q[rd_bank_q][src_idx];
        m_last    = m_valid && (rd_cnt_q == LAST_IDX);
        err_align = err_align_q;
        busy      = (full_q != 2'b00) || (wr_cnt_q != 4'd0);
        s_fire    = s_valid && s_ready;
        m_fire    = m_valid && m_ready;
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block leaves a signal
        // unassigned; that is what keeps it purely combinational instead of a latch.
        bank_d      = bank_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        full_d      = full_q;
        err_align_d = err_align_q;

        if (s_fire) begin
            bank_d[wr_bank_q][wr_cnt_q] = s_data;
            wr_cnt_d = wr_cnt_q + 4'd1;
            if (wr_cnt_q == LAST_IDX) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                wr_cnt_d          = 4'd0;
            end
            // s_last is only a cross-check; the counter alone decides block boundaries.
            if (CHECK_LAST && (s_last != (wr_cnt_q == LAST_IDX))) begin
                err_align_d = 1'b1;
            end
        end

        // A completing write and a completing read always hit different banks.
        if (m_fire) begin
            rd_cnt_d = rd_cnt_q + 4'd1;
            if (rd_cnt_q == LAST_IDX) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
                rd_cnt_d          = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the banks are deliberately reset (unlike most storage arrays) so that
            // m_data reads 0 out of reset and no stale block survives a mid-stream reset.
            bank_q[0]   <= '0;
            bank_q[1]   <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= 4'd0;
            rd_cnt_q    <= 4'd0;
            full_q      <= 2'b00;
            err_align_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples its pre-edge _d value.
            bank_q      <= bank_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            full_q      <= full_d;
            err_align_q <= err_align_d;
        end
    end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Scoreboard bench for shift_rows_stream: forward instance checked against a 4x4 row-rotation
// model, plus an inverse instance that must undo the FIPS-197 ShiftRows example.
module tb_shift_rows_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       s_valid = 1'b0, s_ready, s_last = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       m_valid, m_ready = 1'b0, m_last, err_align, busy;
    logic [7:0] m_data;

    logic       iv_s_valid = 1'b0, iv_s_ready, iv_s_last = 1'b0;
    logic [7:0] iv_s_data = 8'h00;
    logic       iv_m_valid, iv_m_ready = 1'b1, iv_m_last, iv_err_align, iv_busy;
    logic [7:0] iv_m_data;

    shift_rows_stream #(.INVERSE(1'b0), .CHECK_LAST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .err_align(err_align), .busy(busy)
    );

    shift_rows_stream #(.INVERSE(1'b1), .CHECK_LAST(1'b1)) dut_inv (
        .clk(clk), .rst(rst),
        .s_valid(iv_s_valid), .s_ready(iv_s_ready), .s_data(iv_s_data), .s_last(iv_s_last),
        .m_valid(iv_m_valid), .m_ready(iv_m_ready), .m_data(iv_m_data), .m_last(iv_m_last),
        .err_align(iv_err_align), .busy(iv_busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: view the block as a 4x4 matrix; output row r column c takes input
    // row r column (c+r) mod 4 going forward, (c-r) mod 4 for the inverse.
    function automatic void ref_shift(input logic [7:0] blk[16], input bit inv,
                                      output logic [7:0] res[16]);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                int sc;
                sc = inv ? (c - r + 4) % 4 : (c + r) % 4;
                res[4*c + r] = blk[4*sc + r];
            end
        end
    endfunction

    logic [7:0] part[16];
    logic [7:0] res[16];
    int         part_n = 0;
    logic [8:0] exp_q[$];
    logic [7:0] out_log[$];
    logic [8:0] iv_log[$];
    int         in_cyc[$];
    int         out_cyc[$];
    int         cyc = 0;
    logic       stall_prev = 1'b0;
    logic [8:0] stall_val = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: inputs and outputs are stable at the falling edge; a transfer seen here
    // completes on the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            part_n = 0;
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (s_valid && s_ready) begin
                part[part_n] = s_data;
                part_n++;
                in_cyc.push_back(cyc);
                if (part_n == 16) begin
                    ref_shift(part, 1'b0, res);
                    for (int k = 0; k < 16; k++) exp_q.push_back({k == 15, res[k]});
                    part_n = 0;
                end
            end
            if (stall_prev) check("hold_stable", {m_valid, m_last, m_data}, {1'b1, stall_val});
            stall_prev = m_valid && !m_ready;
            stall_val  = {m_last, m_data};
            if (m_valid && m_ready) begin
                out_cyc.push_back(cyc);
                out_log.push_back(m_data);
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_output", {m_last, m_data}, 32'hdead);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("sb_data", m_data, e[7:0]);
                    check("sb_last", m_last, e[8]);
                end
            end
        end
        if (!rst && iv_m_valid && iv_m_ready) iv_log.push_back({iv_m_last, iv_m_data});
    end

    task automatic push(input logic [7:0] b, input bit l);
        int w;
        w = 0;
        s_valid = 1'b1;
        s_data  = b;
        s_last  = l;
        @(negedge clk);
        while (!s_ready && w < 200) begin
            w++;
            @(negedge clk);
        end
        if (!s_ready) check("push_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic push_block(input logic [7:0] blk[16], input int last_at);
        for (int k = 0; k < 16; k++) push(blk[k], k == last_at);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || m_valid) && w < 500) begin
            @(posedge clk);
            w++;
        end
        #1;
        check("drain_done", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_log_fips(input string name, input logic [7:0] exp_blk[16]);
        check({name, "_count"}, out_log.size(), 16);
        for (int k = 0; k < 16 && k < out_log.size(); k++) check(name, out_log[k], exp_blk[k]);
    endtask

    logic [7:0] fips_in[16];
    logic [7:0] fips_out[16];
    logic [7:0] blk[16];

    initial begin
        int acc;
        int w;
        int rdy_cyc;

        for (int i = 0; i < 16; i++) fips_in[i] = 8'(i);
        fips_out = '{8'h00, 8'h05, 8'h0a, 8'h0f, 8'h04, 8'h09, 8'h0e, 8'h03,
                     8'h08, 8'h0d, 8'h02, 8'h07, 8'h0c, 8'h01, 8'h06, 8'h0b};

        // Reset state
        m_ready = 1'b1;
        do_reset();
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        check("rst_err_align", err_align, 0);
        check("rst_busy", busy, 0);

        // FIPS example block
        out_log.delete();
        push_block(fips_in, 15);
        check("fips_valid_after_last", m_valid, 1);
        check("fips_first_byte", m_data, 8'h00);
        drain();
        check_log_fips("fips_out", fips_out);

        // Two back-to-back random blocks, no backpressure
        in_cyc.delete();
        out_cyc.delete();
        out_log.delete();
        for (int i = 0; i < 32; i++) push(8'($urandom), (i % 16) == 15);
        drain();
        check("stream_out_count", out_cyc.size(), 32);
        if (in_cyc.size() == 32 && out_cyc.size() == 32) begin
            check("stream_no_input_gap", in_cyc[31] - in_cyc[0], 31);
            check("stream_latency", out_cyc[0], in_cyc[15] + 1);
            check("stream_no_output_gap", out_cyc[31] - out_cyc[0], 31);
        end

        // Backpressure: both banks fill, then reads free the first bank
        m_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            s_valid = 1'b1;
            s_data  = 8'($urandom);
            s_last  = (acc % 16) == 15;
            @(negedge clk);
            if (s_ready) acc++;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("bp_accepted", acc, 32);
        check("bp_s_ready_low", s_ready, 0);
        check("bp_busy", busy, 1);
        check("bp_m_valid", m_valid, 1);
        out_cyc.delete();
        m_ready = 1'b1;
        w = 0;
        @(negedge clk);
        while (!s_ready && w < 100) begin
            w++;
            @(negedge clk);
        end
        rdy_cyc = cyc;
        check("bp_ready_seen", s_ready, 1);
        check("bp_ready_return", rdy_cyc, (out_cyc.size() >= 16) ? out_cyc[15] + 1 : -1);
        drain();

        // Random gaps on both sides
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    push(8'($urandom), (i % 16) == 15);
                end
            end
            begin
                repeat (250) begin
                    @(posedge clk);
                    #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
                m_ready = 1'b1;
            end
        join
        m_ready = 1'b1;
        drain();
        check("rand_err_clear", err_align, 0);

        // Misplaced s_last
        do_reset();
        out_log.delete();
        for (int k = 0; k < 16; k++) begin
            push(fips_in[k], k == 7);
            if (k == 6) check("align_before", err_align, 0);
            if (k == 7) check("align_set", err_align, 1);
        end
        drain();
        check("align_sticky", err_align, 1);
        check_log_fips("align_out", fips_out);
        do_reset();
        check("align_rst_clear", err_align, 0);

        // Reset in the middle of a block
        for (int k = 0; k < 9; k++) push(8'($urandom), 1'b0);
        check("midrst_busy_before", busy, 1);
        do_reset();
        check("midrst_m_valid", m_valid, 0);
        check("midrst_s_ready", s_ready, 1);
        check("midrst_busy", busy, 0);
        out_log.delete();
        push_block(fips_in, 15);
        drain();
        check_log_fips("midrst_out", fips_out);

        // Inverse instance undoes the FIPS example
        iv_log.delete();
        iv_m_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            iv_s_valid = 1'b1;
            iv_s_data  = fips_out[k];
            iv_s_last  = (k == 15);
            w = 0;
            @(negedge clk);
            while (!iv_s_ready && w < 100) begin
                w++;
                @(negedge clk);
            end
            @(posedge clk);
            #1;
        end
        iv_s_valid = 1'b0;
        iv_s_last  = 1'b0;
        w = 0;
        while (iv_log.size() < 16 && w < 100) begin
            @(posedge clk);
            w++;
        end
        #1;
        check("inv_count", iv_log.size(), 16);
        ref_shift(fips_out, 1'b1, blk);
        for (int k = 0; k < 16 && k < iv_log.size(); k++) begin
            check("inv_data", iv_log[k][7:0], 8'(k));
            check("inv_model", iv_log[k][7:0], blk[k]);
            check("inv_last", iv_log[k][8], k == 15);
        end
        check("inv_err", iv_err_align, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
